cpu_instr_sequencer: RTL and testbench

- Issuing end of the cpu instruction interface: holds a small loadable program and drives the 13-bit instr bus into cpu, one instruction at a time.
- Each instruction is held for the number of cycles its class needs.
- Captures cpu result after every ALU instruction and reports completion.
- Replaces hand-timed instruction driving in benches and top-level bring-up.

---
 rtl/cpu_instr_sequencer_pkg.sv | 49 ++++
 rtl/cpu_instr_sequencer_if.sv | 39 +++
 rtl/cpu_instr_sequencer_prog_mem.sv | 39 +++
 rtl/cpu_instr_sequencer.sv | 150 +++++++++++++++
 tb/tb_cpu_instr_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_instr_sequencer_pkg.sv
// cpu_pkg: shared constants and types for the cpu instruction sequencer.
// Holds the instruction word layout, opcode values, the sequencer state
// enum and a small decode helper. No ports.
package cpu_pkg;

  localparam int INSTR_W = 13;
  localparam int DATA_W  = 8;
  localparam int REG_W   = 3;

  // Field positions. Immediate form: [12]=1, [11:9] rd, [8]=0, [7:0] imm.
  // Register form: [12]=0, [11:9] ra, [8:6] rb, [5:3] rd, [2:0] op.
  localparam int MODE_BIT   = 12;
  localparam int RD_I_MSB   = 11;
  localparam int RD_I_LSB   = 9;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;
  localparam int RA_MSB     = 11;
  localparam int RA_LSB     = 9;
  localparam int RB_MSB     = 8;
  localparam int RB_LSB     = 6;
  localparam int RD_R_MSB   = 5;
  localparam int RD_R_LSB   = 3;
  localparam int OP_MSB     = 2;
  localparam int OP_LSB     = 0;

  localparam logic [REG_W-1:0] OP_NOP = 3'b000;
  localparam logic [REG_W-1:0] OP_MOV = 3'b001;
  localparam logic [REG_W-1:0] OP_ADD = 3'b010;
  localparam logic [REG_W-1:0] OP_SUB = 3'b011;
  localparam logic [REG_W-1:0] OP_AND = 3'b100;
  localparam logic [REG_W-1:0] OP_OR  = 3'b101;
  localparam logic [REG_W-1:0] OP_XOR = 3'b110;
  localparam logic [REG_W-1:0] OP_SHL = 3'b111;

  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // A register-mode word with a non-zero op produces a result on the cpu.
  function automatic logic is_alu(input logic mode, input logic [REG_W-1:0] op);
    return !mode && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/cpu_instr_sequencer_if.sv
// Bus between a program/controller side (master) and the instruction
// sequencer (slave).
//   prog_we/prog_addr/prog_data : program memory write port
//   prog_len                    : run length, sampled on start
//   start/stop                  : run control
//   result_in                   : cpu result bus
//   instr/busy/done/result/result_valid/pc : sequencer outputs
interface cpu_instr_sequencer_if #(
  parameter int DEPTH = 16
);
  import cpu_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [AW:0]        prog_len;
  logic               start;
  logic               stop;
  logic [DATA_W-1:0]  result_in;
  logic [INSTR_W-1:0] instr;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  result;
  logic               result_valid;
  logic [AW-1:0]      pc;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, stop, result_in,
    input  instr, busy, done, result, result_valid, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, stop, result_in,
    output instr, busy, done, result, result_valid, pc
  );

endinterface

// File: rtl/cpu_instr_sequencer_prog_mem.sv
// instr_prog_mem: DEPTH x 13 program store, one write port and one
// synchronous read port. The read register doubles as the instruction
// output register: clr forces it to NOP, re loads mem[raddr], otherwise
// it holds. Contents are never reset.
//   clk         : clock
//   we/waddr/wdata : write port
//   re/raddr    : synchronous read
//   clr         : load NOP into the read register (wins over re)
//   rdata       : registered read data
module instr_prog_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [INSTR_W-1:0]         wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  input  logic                       clr,
  output logic [INSTR_W-1:0]         rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr)     rdata_q <= INSTR_NOP;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: plays a loaded program onto the cpu instruction bus,
// holding each word for its class's cycle count, capturing the cpu result
// after ALU words and pulsing done at the end of a run.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave side of cpu_instr_sequencer_if (program port, run
//           control, result_in, and all sequencer outputs)
//
// state | meaning
// IDLE  | waiting; program writes and start accepted
// FETCH | memory read of mem[pc], instr=NOP
// HOLD  | fetched word on instr for IMM_CYCLES / ALU_CYCLES cycles
// DONE  | one-cycle done pulse, then IDLE
module cpu_instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int IMM_CYCLES = 1,
  parameter int ALU_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_instr_sequencer_if.slave bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int MAXH = (IMM_CYCLES > ALU_CYCLES) ? IMM_CYCLES : ALU_CYCLES;
  localparam int CW   = $clog2(MAXH + 1);

  seq_state_e         state_q;
  logic [AW-1:0]      pc_q;
  logic [LW-1:0]      len_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               first_q;
  logic               busy_q;
  logic               done_q;
  logic [DATA_W-1:0]  result_q;
  logic               rv_q;

  logic [INSTR_W-1:0] instr_w;
  logic [CW-1:0]      hold_len, cnt_cur;
  logic               last_hold, hold_keep;
  logic               mem_we, mem_re, mem_clr;
  logic [LW-1:0]      start_len;

  // The fetched word is only visible once HOLD begins, so the hold count is
  // taken from it on the first HOLD cycle and counted down from there.
  always_comb begin
    hold_len  = instr_w[MODE_BIT] ? CW'(IMM_CYCLES) : CW'(ALU_CYCLES);
    cnt_cur   = first_q ? hold_len : cnt_q;
    cnt_d     = cnt_cur - CW'(1);
    last_hold = (state_q == HOLD) && (cnt_cur == CW'(1));
    hold_keep = (state_q == HOLD) && !last_hold && !bus.stop;
    mem_re    = (state_q == FETCH) && !bus.stop;
    mem_clr   = !reset || !(mem_re || hold_keep);
    mem_we    = reset && (state_q == IDLE) && bus.prog_we;
    start_len = (bus.prog_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.prog_len;
  end

  instr_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .re    (mem_re),
    .raddr (pc_q),
    .clr   (mem_clr),
    .rdata (instr_w)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rv_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            len_q  <= start_len;
            pc_q   <= '0;
            busy_q <= 1'b1;
            if (start_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= HOLD;
            first_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            first_q <= 1'b0;
            cnt_q   <= cnt_d;
            if (last_hold) begin
              if (is_alu(instr_w[MODE_BIT], instr_w[OP_MSB:OP_LSB])) begin
                result_q <= bus.result_in;
                rv_q     <= 1'b1;
              end
              pc_q <= pc_q + AW'(1);
              if (LW'(pc_q) == len_q - LW'(1)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= FETCH;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr        = instr_w;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.pc           = pc_q;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Bench for cpu_instr_sequencer: directed steps plus randomized programs,
// checked cycle by cycle against a trace built from the program listing.
module tb_cpu_instr_sequencer;
  import cpu_pkg::*;

  localparam int DEPTH = 16;
  localparam int IMM   = 1;
  localparam int ALU   = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int MAXC  = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_instr_sequencer_if #(.DEPTH(DEPTH)) bus ();

  cpu_instr_sequencer #(.DEPTH(DEPTH), .IMM_CYCLES(IMM), .ALU_CYCLES(ALU)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [12:0] prog   [DEPTH];
  logic [7:0]  cur_res;
  logic [7:0]  rin    [MAXC];
  logic [12:0] e_instr[MAXC];
  logic        e_busy [MAXC];
  logic        e_done [MAXC];
  logic        e_rv   [MAXC];
  logic [7:0]  e_res  [MAXC];
  int          e_pc   [MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] rand_word(input bit imm);
    logic [12:0] w;
    w = 13'($urandom);
    w[12] = imm;
    if (imm) w[8] = 1'b0;
    return w;
  endfunction

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic load(input int a, input logic [12:0] w);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(a);
    bus.prog_data = w;
    @(posedge clk); #1;
    bus.prog_we = 1'b0;
    prog[a] = w;
  endtask

  task automatic load_add_prog();
    load(0, 13'b1_011_0_00000100);
    load(1, 13'b1_010_0_00000011);
    load(2, 13'b0_011_010_001_010);
  endtask

  // Runs one program and compares every cycle to a trace derived from the
  // listing: per instruction one NOP cycle then the word for its hold count.
  task automatic run(input int plen, input bit inject, input bit wr0,
                     input logic [12:0] w0, input int rin_fix);
    int L, k, h, last;
    logic [7:0]  res;
    logic [12:0] w;
    if (wr0) prog[0] = w0;
    L = (plen > DEPTH) ? DEPTH : plen;
    for (int c = 0; c < MAXC; c++) begin
      rin[c]     = (rin_fix >= 0) ? 8'(rin_fix) : 8'($urandom);
      e_instr[c] = '0; e_busy[c] = 0; e_done[c] = 0; e_rv[c] = 0;
      e_res[c]   = '0; e_pc[c] = L % DEPTH;
    end
    res = cur_res;
    k = 1;
    for (int i = 0; i < L; i++) begin
      w = prog[i];
      h = w[12] ? IMM : ALU;
      for (int j = 0; j <= h; j++) begin
        e_instr[k] = (j == 0) ? 13'h0 : w;
        e_busy[k]  = 1'b1;
        e_res[k]   = res;
        e_pc[k]    = i;
        k++;
      end
      if (!w[12] && w[2:0] != 3'b000) begin
        res = rin[k-1];
        e_rv[k] = 1'b1;
      end
    end
    e_done[k] = 1'b1; e_busy[k] = 1'b1; e_res[k] = res;
    last = k;
    e_res[last+1] = res;
    e_res[last+2] = res;

    bus.prog_len  = (AW+1)'(plen);
    bus.start     = 1'b1;
    bus.result_in = rin[0];
    if (wr0) begin
      bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_data = w0;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.prog_we = 1'b0;
    for (int c = 1; c <= last + 2; c++) begin
      bus.result_in = rin[c];
      if (inject && c == 2) begin
        bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_data = ~prog[0];
        bus.start = 1'b1; bus.prog_len = 1;
      end
      @(negedge clk);
      chk($sformatf("instr L=%0d c=%0d", plen, c), 32'(bus.instr), 32'(e_instr[c]));
      chk($sformatf("busy L=%0d c=%0d", plen, c), 32'(bus.busy), 32'(e_busy[c]));
      chk($sformatf("done L=%0d c=%0d", plen, c), 32'(bus.done), 32'(e_done[c]));
      chk($sformatf("rvalid L=%0d c=%0d", plen, c), 32'(bus.result_valid), 32'(e_rv[c]));
      chk($sformatf("result L=%0d c=%0d", plen, c), 32'(bus.result), 32'(e_res[c]));
      chk($sformatf("pc L=%0d c=%0d", plen, c), 32'(bus.pc), 32'(e_pc[c]));
      @(posedge clk); #1;
      bus.prog_we = 1'b0; bus.start = 1'b0;
    end
    cur_res = res;
  endtask

  // Starts the 3-word program and returns at the start of cycle 6, the
  // first hold cycle of the ALU word.
  task automatic start_to_cycle6();
    bus.prog_len  = 3;
    bus.start     = 1'b1;
    bus.result_in = ~cur_res;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    reset = 1'b0;
    bus.prog_we = 1'b1; bus.prog_addr = AW'($urandom); bus.prog_data = 13'($urandom);
    bus.prog_len = 5'($urandom); bus.start = 1'b1; bus.stop = 1'b1;
    bus.result_in = 8'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset instr", 32'(bus.instr), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset result", 32'(bus.result), 0);
    chk("reset rvalid", 32'(bus.result_valid), 0);
    chk("reset pc", 32'(bus.pc), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.prog_we = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.prog_len = 0;
    cur_res = '0;

    for (int i = 0; i < DEPTH; i++) load(i, rand_word(1'($urandom_range(0, 1))));
    load_add_prog();
    run(3, 0, 0, '0, 8'h07);

    // stop in cycle 6
    start_to_cycle6();
    chk("stop pre instr", 32'(bus.instr), 32'(prog[2]));
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    @(negedge clk);
    chk("stop instr", 32'(bus.instr), 0);
    chk("stop busy", 32'(bus.busy), 0);
    chk("stop rvalid", 32'(bus.result_valid), 0);
    chk("stop result", 32'(bus.result), 32'(cur_res));
    chk("stop pc", 32'(bus.pc), 2);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("stop nodone %0d", c), 32'(bus.done), 0);
      chk($sformatf("stop norv %0d", c), 32'(bus.result_valid), 0);
    end
    @(posedge clk); #1;

    run(0, 0, 0, '0, -1);

    for (int i = 0; i < DEPTH; i++) load(i, rand_word(1'b1));
    run(DEPTH, 0, 0, '0, -1);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < DEPTH; i++) load(i, rand_word(1'($urandom_range(0, 1))));
      run($urandom_range(1, 2 * DEPTH - 1), 0, n == 1, rand_word(1'b0), -1);
    end

    // write and start while busy are both ignored
    for (int i = 0; i < DEPTH; i++) load(i, rand_word(1'($urandom_range(0, 1))));
    run(4, 1, 0, '0, -1);
    run(4, 0, 0, '0, -1);

    // reset during the ALU hold
    load_add_prog();
    start_to_cycle6();
    chk("rst pre instr", 32'(bus.instr), 32'(prog[2]));
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst instr", 32'(bus.instr), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst result", 32'(bus.result), 0);
    chk("rst rvalid", 32'(bus.result_valid), 0);
    chk("rst pc", 32'(bus.pc), 0);
    @(posedge clk); #1;
    cur_res = '0;
    run(3, 0, 0, '0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
